// File: rtl/debounce_fsm_if.sv
// debounce_fsm_if: raw switch input and debounced outputs; db_tick exists only with DEBOUNCE_TICK_EN
interface debounce_fsm_if;
   logic sw;
   logic db_level;
`ifdef DEBOUNCE_TICK_EN
   logic db_tick;
   modport master (output sw, input db_level, input db_tick);
   modport slave (input sw, output db_level, output db_tick);
`else
   modport master (output sw, input db_level);
   modport slave (input sw, output db_level);
`endif
endinterface

// File: rtl/debounce_fsm.sv
// debounce_fsm: synchronizer plus 4-state Moore debouncer; optional db_tick pulse under DEBOUNCE_TICK_EN
module debounce_fsm #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 1000000,
   parameter int CNT_W       = 20
) (
   input  logic          clk,
   input  logic          reset_n,
   debounce_fsm_if.slave bus
);
   typedef enum logic [1:0] {ZERO = 2'b00, WAIT1 = 2'b01, ONE = 2'b11, WAIT0 = 2'b10} state_t;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DB_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   assign s = sync[SYNC_STAGES-1];
   // Gray-style ring encoding puts the debounced level directly in state bit 1
   assign bus.db_level = state[1];
   // shift raw input through the synchronizer chain
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) sync <= '0;
      else sync <= {sync[SYNC_STAGES-2:0], bus.sw};
`ifdef DEBOUNCE_TICK_EN
   logic tick;
   assign bus.db_tick = tick;
`endif
   // debounce FSM: a WAIT state commits only after DB_CYCLES stable samples
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= ZERO;
         cnt   <= '0;
`ifdef DEBOUNCE_TICK_EN
         tick  <= 1'b0;
`endif
      end else begin
`ifdef DEBOUNCE_TICK_EN
         tick <= 1'b0;
`endif
         case (state)
            ZERO:
               if (s) begin
                  state <= WAIT1;
                  cnt   <= RELOAD;
               end
            WAIT1:
               if (!s) state <= ZERO;
               else if (cnt == '0) begin
                  state <= ONE;
`ifdef DEBOUNCE_TICK_EN
                  tick  <= 1'b1;
`endif
               end else cnt <= cnt - CNT_W'(1);
            ONE:
               if (!s) begin
                  state <= WAIT0;
                  cnt   <= RELOAD;
               end
            WAIT0:
               if (s) state <= ONE;
               else if (cnt == '0) state <= ZERO;
               else cnt <= cnt - CNT_W'(1);
            default: state <= ZERO;
         endcase
      end
endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: directed scoreboard bench for debounce_fsm (DB_CYCLES=8 and DB_CYCLES=1 instances)
module tb_debounce_fsm;
   logic clk;
   logic reset_n;
   int checks;
   int failures;
   logic in_rst;
   logic [15:0] h;
   logic lev1, lev2;
   logic [3:0] sb[$];
   debounce_fsm_if b1();
   debounce_fsm_if b2();
   debounce_fsm #(.SYNC_STAGES(2), .DB_CYCLES(8), .CNT_W(4)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
   debounce_fsm #(.SYNC_STAGES(2), .DB_CYCLES(1), .CNT_W(4)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask
   // level changes once the last DB_CYCLES+1 samples, delayed by two sync stages, all agree
   task automatic cyc(input logic v);
      logic [3:0] e;
      logic r1, f1, r2, f2;
      b1.sw = v;
      b2.sw = v;
      h  = {h[14:0], in_rst ? 1'b0 : v};
      r1 = !in_rst && !lev1 && (&h[10:2]);
      f1 = !in_rst && lev1 && (h[10:2] == 9'd0);
      r2 = !in_rst && !lev2 && (&h[3:2]);
      f2 = !in_rst && lev2 && (h[3:2] == 2'd0);
      lev1 = in_rst ? 1'b0 : r1 ? 1'b1 : f1 ? 1'b0 : lev1;
      lev2 = in_rst ? 1'b0 : r2 ? 1'b1 : f2 ? 1'b0 : lev2;
      sb.push_back({lev1, r1, lev2, r2});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("level_db8", b1.db_level, e[3]);
      chk("level_db1", b2.db_level, e[1]);
`ifdef DEBOUNCE_TICK_EN
      chk("tick_db8", b1.db_tick, e[2]);
      chk("tick_db1", b2.db_tick, e[0]);
`endif
      @(negedge clk);
   endtask
   task automatic run(input logic v, input int n);
      for (int i = 0; i < n; i++) cyc(v);
   endtask
   task automatic assert_reset();
      reset_n = 1'b0;
      in_rst  = 1'b1;
      h       = '0;
      lev1    = 1'b0;
      lev2    = 1'b0;
      #1;
      chk("rst_level_db8", b1.db_level, 1'b0);
      chk("rst_level_db1", b2.db_level, 1'b0);
      chk("rst_state_zero", u1.state === 2'b00, 1'b1);
   endtask
   task automatic release_reset();
      reset_n = 1'b1;
      in_rst  = 1'b0;
   endtask
   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      in_rst   = 1'b1;
      h        = '0;
      lev1     = 1'b0;
      lev2     = 1'b0;
      b1.sw    = 1'b1;
      b2.sw    = 1'b1;
      @(negedge clk);
      assert_reset();
      for (int i = 0; i < 6; i++) cyc(i[0]);
      release_reset();
      run(1'b0, 20);
      run(1'b1, 14);
      run(1'b0, 14);
      run(1'b1, 5);
      run(1'b0, 2);
      run(1'b1, 6);
      run(1'b0, 4);
      run(1'b1, 12);
      for (int i = 0; i < 7; i++) begin
         cyc(i < 3 ? 1'b0 : 1'b1);
         chk("bounce_not_zero", u1.state !== 2'b00, 1'b1);
      end
      run(1'b0, 14);
      run(1'b1, 6);
      chk("midwait_state", u1.state === 2'b01, 1'b1);
      chk("midwait_cnt4", u1.cnt === 4'd4, 1'b1);
      assert_reset();
      cyc(1'b1);
      release_reset();
      run(1'b1, 14);
      run(1'b0, 12);
      chk("scoreboard_empty", sb.size() == 0, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
